// File: rtl/qam16_modulator.sv
// qam16_modulator: 16QAM passband test-stimulus transmitter.
// Packs a serial bit stream into Gray-mapped I/Q symbols held for SPS
// samples, mixes them onto an NCO carrier and emits one 8-bit signed
// sample per clk.
// Ports:
//   clk, rst          clock (sample rate), async active-high reset
//   din, din_valid    serial bit in, qualified by din_valid
//   din_ready         packer has room (fewer than 4 bits buffered)
//   dout              signed passband sample
//   di, dq            I/Q level of the symbol currently at dout
//   sym_strobe        first dout sample of each symbol
//   underrun          symbol boundary hit with fewer than 4 bits
module qam16_modulator #(
   parameter int unsigned        SPS       = 8,
   parameter int unsigned        PHASE_W   = 32,
   parameter logic [PHASE_W-1:0] FREQ_WORD = 32'h4000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic signed [7:0] dout,
   output logic signed [2:0] di,
   output logic signed [2:0] dq,
   output logic              sym_strobe,
   output logic              underrun
);

   localparam int unsigned    SCW      = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [SCW-1:0] SYM_LAST = SCW'(SPS - 1);

   // Quarter-wave table: round(127*cos(2*pi*k/64)), k = 0..16.
   function automatic logic signed [7:0] qtab(input logic [4:0] k);
      case (k)
         5'd0:    qtab = 8'sd127;
         5'd1:    qtab = 8'sd126;
         5'd2:    qtab = 8'sd125;
         5'd3:    qtab = 8'sd122;
         5'd4:    qtab = 8'sd117;
         5'd5:    qtab = 8'sd112;
         5'd6:    qtab = 8'sd106;
         5'd7:    qtab = 8'sd98;
         5'd8:    qtab = 8'sd90;
         5'd9:    qtab = 8'sd81;
         5'd10:   qtab = 8'sd71;
         5'd11:   qtab = 8'sd60;
         5'd12:   qtab = 8'sd49;
         5'd13:   qtab = 8'sd37;
         5'd14:   qtab = 8'sd25;
         5'd15:   qtab = 8'sd12;
         default: qtab = 8'sd0;
      endcase
   endfunction

   // Full cosine from quarter-wave symmetry.
   function automatic logic signed [7:0] cos_lut(input logic [5:0] k);
      if (k <= 6'd16)      cos_lut = qtab(k[4:0]);
      else if (k <= 6'd32) cos_lut = -qtab(5'(6'd32 - k));
      else if (k <= 6'd48) cos_lut = -qtab(5'(k - 6'd32));
      else                 cos_lut = qtab(5'(6'd0 - k));
   endfunction

   // Gray map of a bit pair to a signed level.
   function automatic logic signed [2:0] gray(input logic [1:0] b);
      case (b)
         2'b00:   gray = -3'sd3;
         2'b01:   gray = -3'sd1;
         2'b11:   gray = 3'sd1;
         default: gray = 3'sd3;
      endcase
   endfunction

   logic [3:0]         buf_q, buf_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [SCW-1:0]     scnt_q, scnt_d;
   logic [PHASE_W-1:0] ph_q;
   logic signed [2:0]  si_q, si_d, sq_q, sq_d;
   logic               stb0_q, ur_q, ur_d;
   logic signed [7:0]  cos_q, sin_q;
   logic signed [2:0]  i1_q, q1_q, i2_q, q2_q, di_q, dq_q;
   logic               stb1_q, stb2_q, stb3_q;
   logic signed [10:0] pi_q, pq_q, pi_d, pq_d;
   logic signed [11:0] s_d;
   logic signed [7:0]  dout_q;
   logic               acc, bnd, full;
   logic [5:0]         idx;

   assign full      = (cnt_q == 3'd4);
   assign din_ready = ~full;
   assign acc       = din_valid & din_ready;
   assign bnd       = (scnt_q == SYM_LAST);
   assign idx       = ph_q[PHASE_W-1 -: 6];

   always_comb begin
      buf_d  = buf_q;
      cnt_d  = cnt_q;
      scnt_d = bnd ? '0 : scnt_q + SCW'(1);
      si_d   = si_q;
      sq_d   = sq_q;
      ur_d   = bnd & ~full;
      if (acc) begin
         buf_d = {buf_q[2:0], din};
         cnt_d = cnt_q + 3'd1;
      end
      if (bnd) begin
         // A short buffer sends the zero symbol; partial bits are kept.
         si_d = full ? gray(buf_q[3:2]) : 3'sd0;
         sq_d = full ? gray(buf_q[1:0]) : 3'sd0;
         if (full) cnt_d = 3'd0;
      end
   end

   // Operands sign-extended to 11 bits so the product is not truncated.
   assign pi_d = $signed({{8{i1_q[2]}}, i1_q}) * $signed({{3{cos_q[7]}}, cos_q});
   assign pq_d = $signed({{8{q1_q[2]}}, q1_q}) * $signed({{3{sin_q[7]}}, sin_q});
   assign s_d  = 12'(pi_q) - 12'(pq_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= '0;
         cnt_q  <= '0;
         scnt_q <= '0;
         ph_q   <= '0;
         si_q   <= '0;
         sq_q   <= '0;
         stb0_q <= 1'b0;
         ur_q   <= 1'b0;
         cos_q  <= '0;
         sin_q  <= '0;
         i1_q   <= '0;
         q1_q   <= '0;
         stb1_q <= 1'b0;
         pi_q   <= '0;
         pq_q   <= '0;
         i2_q   <= '0;
         q2_q   <= '0;
         stb2_q <= 1'b0;
         dout_q <= '0;
         di_q   <= '0;
         dq_q   <= '0;
         stb3_q <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         cnt_q  <= cnt_d;
         scnt_q <= scnt_d;
         ph_q   <= ph_q + FREQ_WORD;
         si_q   <= si_d;
         sq_q   <= sq_d;
         stb0_q <= bnd;
         ur_q   <= ur_d;
         // sin(x) = cos(x - quarter turn)
         cos_q  <= cos_lut(idx);
         sin_q  <= cos_lut(idx - 6'd16);
         i1_q   <= si_q;
         q1_q   <= sq_q;
         stb1_q <= stb0_q;
         pi_q   <= pi_d;
         pq_q   <= pq_d;
         i2_q   <= i1_q;
         q2_q   <= q1_q;
         stb2_q <= stb1_q;
         dout_q <= 8'(s_d >>> 3);
         di_q   <= i2_q;
         dq_q   <= q2_q;
         stb3_q <= stb2_q;
      end
   end

   assign dout       = dout_q;
   assign di         = di_q;
   assign dq         = dq_q;
   assign sym_strobe = stb3_q;
   assign underrun   = ur_q;

endmodule

// File: tb/tb_qam16_modulator.sv
// tb_qam16_modulator: directed bench for qam16_modulator
// (defaults: SPS=8, carrier at fs/4).
module tb_qam16_modulator;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              din = 1'b0;
   logic              din_valid = 1'b0;
   logic              din_ready;
   logic signed [7:0] dout;
   logic signed [2:0] di, dq;
   logic              sym_strobe, underrun;

   int ntests = 0;
   int nfail  = 0;
   bit q[$];
   int seq[$];

   always #5 clk = ~clk;

   qam16_modulator dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .di         (di),
      .dq         (dq),
      .sym_strobe (sym_strobe),
      .underrun   (underrun)
   );

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input int exp);
      ntests++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive();
      din_valid = (q.size() > 0);
      din       = (q.size() > 0) ? q[0] : 1'b0;
   endtask

   task automatic tick();
      bit a;
      a = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (a) void'(q.pop_front());
      drive();
   endtask

   function automatic int lv(input int b2);
      case (b2)
         0:       return -3;
         1:       return -1;
         3:       return 1;
         default: return 3;
      endcase
   endfunction

   // floor(L*127/8) for each level
   function automatic int amp(input int l);
      case (l)
         -3:      return -48;
         -1:      return -16;
         1:       return 15;
         3:       return 47;
         default: return 0;
      endcase
   endfunction

   task automatic push_sym(input int s);
      for (int b = 3; b >= 0; b--) q.push_back(s[b]);
   endtask

   task automatic check_sym(input string tag, input int iv, input int qv,
                            input bit ur, input bit rc);
      int e;
      for (int j = 0; j < 8; j++) begin
         tick();
         case (j % 4)
            0:       e = amp(iv);
            1:       e = amp(-qv);
            2:       e = amp(-iv);
            default: e = amp(qv);
         endcase
         chk({tag, ".dout"}, dout, e);
         chk({tag, ".di"}, di, iv);
         chk({tag, ".dq"}, dq, qv);
         chk({tag, ".strobe"}, sym_strobe, (j == 0) ? 1 : 0);
         chk({tag, ".underrun"}, underrun, (j == 5 && ur) ? 1 : 0);
         if (rc) chk({tag, ".ready"}, din_ready, (j >= 1 && j <= 4) ? 0 : 1);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.dout", dout, 0);
      chk("rst.di", di, 0);
      chk("rst.dq", dq, 0);
      chk("rst.strobe", sym_strobe, 0);
      chk("rst.underrun", underrun, 0);
      chk("rst.ready", din_ready, 1);

      seq = '{0, 0, 0, 10, 10, 10};
      for (int s = 0; s < 16; s++) seq.push_back(s);
      foreach (seq[n]) push_sym(seq[n]);
      drive();
      rst = 1'b0;

      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("start.dout", dout, 0);
         chk("start.underrun", underrun, 0);
         if (k == 4) chk("start.ready_lo", din_ready, 0);
         if (k == 8) chk("start.ready_hi", din_ready, 1);
      end

      foreach (seq[n]) begin
         check_sym($sformatf("sym%0d_%0d", n, seq[n]),
                   lv(seq[n] >> 2), lv(seq[n] & 3),
                   n == seq.size() - 1, n != seq.size() - 1);
      end

      check_sym("zero1", 0, 0, 1'b1, 1'b0);
      push_sym(12);
      push_sym(6);
      push_sym(3);
      push_sym(5);
      drive();
      check_sym("zero2", 0, 0, 1'b0, 1'b0);
      check_sym("res1100", 1, -3, 1'b0, 1'b1);
      check_sym("res0110", -1, 3, 1'b0, 1'b1);

      rst = 1'b1;
      #1;
      chk("mid.dout", dout, 0);
      chk("mid.di", di, 0);
      chk("mid.dq", dq, 0);
      chk("mid.strobe", sym_strobe, 0);
      chk("mid.underrun", underrun, 0);
      chk("mid.ready", din_ready, 1);
      q.delete();
      q.push_back(1'b1);
      q.push_back(1'b1);
      q.push_back(1'b1);
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("post.dout", dout, 0);
         chk("post.underrun", underrun, (k == 8) ? 1 : 0);
         if (k == 8) begin
            chk("post.ready", din_ready, 1);
            q.push_back(1'b1);
            drive();
         end
      end
      check_sym("post_zero", 0, 0, 1'b0, 1'b0);
      check_sym("post1111", 1, 1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
